fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 16-bit 5-stage CPU.
- Drives the PC, reads instruction memory and presents the IF/ID instruction to decode and to the hazard-detect unit.
- Consumes that unit's `hazard` flag to freeze fetch and inject bubbles into ID/EX.
- Consumes branch/jump redirects from EX to flush the wrong-path instruction.
- Watchdog force-releases a stall held longer than MAX_STALL cycles.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width.
- NOP_INSTR, 16'h0000, instruction word inserted on flush/reset; treated as harmless.
- HALT_OP, 4'hF, opcode (bits [15:12]) of HLT.
- MAX_STALL, 3, maximum consecutive hazard-stall cycles before forced release.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_addr  out  ADDR_W  instruction-memory address; always equals pc.
- imem_data  in  16  instruction at imem_addr, valid in the same cycle (combinational read).
- hazard  in  1  from hazard detect; asserted while the IF/ID instruction must not issue.
- redirect  in  1  taken branch/jump/JR resolved in EX.
- redirect_pc  in  ADDR_W  target address, valid when redirect=1.
- if_id_instr  out  16  IF/ID instruction register; also feeds hazard detect `instr_in`.
- if_id_pc1  out  ADDR_W  PC+1 of the IF/ID instruction, used by JAL/branch offsets.
- if_id_valid  out  1  IF/ID holds a real, non-flushed instruction.
- id_bubble  out  1  combinational; ID/EX must load NOP this cycle.
- halted  out  1  HLT reached IF/ID; fetch frozen.
- stall_timeout  out  1  one-cycle pulse when the watchdog forces release.
- fetch_count  out  16  number of instructions loaded into IF/ID with valid=1; wraps.

Behaviour:
- Reset state: pc=0, if_id_instr=NOP_INSTR, if_id_pc1=0, if_id_valid=0, halted=0, stall_timeout=0, fetch_count=0, stall_cnt=0.
- rst has priority over every other input.
- PC increment: pc+1 in ADDR_W bits; wraps 16'hFFFF -> 0.
- Per-cycle priority, highest first: rst > redirect > stall > halted > normal.
- redirect=1:
  - pc <= redirect_pc.
  - IF/ID <= NOP_INSTR, valid=0.
  - stall_cnt <= 0; halted <= 0.
  - Overrides a simultaneous hazard.
- Stall = hazard & if_id_valid & (stall_cnt < MAX_STALL):
  - pc, IF/ID and fetch_count hold.
  - stall_cnt increments.
  - hazard while if_id_valid=0 is ignored.
- Forced release = hazard & if_id_valid & (stall_cnt == MAX_STALL):
  - Proceed as normal.
  - stall_timeout pulses 1 for the next cycle.
  - stall_cnt <= 0.
- Normal advance:
  - IF/ID <= imem_data, if_id_pc1 <= pc+1, valid=1.
  - pc <= pc+1; fetch_count += 1.
  - stall_cnt <= 0.
  - If imem_data[15:12]==HALT_OP, halted <= 1 in the same edge.
- halted=1:
  - pc and IF/ID hold; HLT stays in IF/ID with valid=1; fetch_count holds.
  - Exit only by redirect or rst.
  - hazard during halt stalls normally; it never unfreezes.
- id_bubble = if_id_valid & hazard & ~redirect & (stall_cnt < MAX_STALL). Also 1 whenever if_id_valid=0.
- Latency: instruction at pc appears on if_id_instr one cycle after pc presents it.
- Reset mid-stall or mid-halt clears all state in one cycle; no pulse on stall_timeout.

Test Plan:
- Straight-line fetch: imem[0..3]=16'h1123,16'h2456,16'h3789,16'h4ABC, no hazard.
  - if_id_instr follows 1 cycle late; if_id_pc1=1,2,3,4; fetch_count=4 after 4 cycles.
- Hazard 2 cycles with IF/ID=16'h2456:
  - pc holds at 2; IF/ID holds; id_bubble=1 for exactly 2 cycles.
  - fetch_count unchanged; then resumes with 16'h3789.
- Hazard held 5 cycles:
  - 3 stall cycles (id_bubble=1), then forced advance.
  - stall_timeout=1 for one cycle; stall_cnt restarts, next stall counts from 0.
- redirect=1, redirect_pc=16'h0040, same cycle as hazard=1:
  - Next cycle pc=16'h0040, if_id_instr=16'h0000, if_id_valid=0, id_bubble=1.
  - Following cycle if_id_instr=imem[0x40].
- imem[5]=16'hF000:
  - halted=1 the cycle HLT enters IF/ID; pc frozen at 6 for 10 cycles.
  - redirect to 16'h0010 clears halted and fetches imem[0x10].
- rst during stall (stall_cnt=2) and at pc=16'hFFFF wrap test:
  - After rst, all outputs at reset values.
  - Separately, pc 16'hFFFF advances to 16'h0000 with if_id_pc1=16'h0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit 5-stage CPU.
// Handles hazard stalls with a watchdog release, EX redirects, and HLT freezing.
module fetch_stage #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HALT_OP   = 4'hF,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              hazard,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc1,
  output logic              if_id_valid,
  output logic              id_bubble,
  output logic              halted,
  output logic              stall_timeout,
  output logic [15:0]       fetch_count
);

  localparam int unsigned     CNT_W     = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       count_q, count_d;

  logic [ADDR_W-1:0] pc_inc;
  logic              under_lim;
  logic              stall;
  logic              forced;

  assign pc_inc    = pc_q + ADDR_W'(1);
  assign under_lim = (stall_cnt_q < STALL_LIM);
  assign stall     = hazard & valid_q & under_lim;
  assign forced    = hazard & valid_q & (stall_cnt_q == STALL_LIM);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc1_d       = pc1_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = 1'b0;
    count_d     = count_q;

    if (redirect) begin
      pc_d        = redirect_pc;
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      stall_cnt_d = '0;
      state_d     = ST_RUN;
    end else if (stall) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      // A watchdog release behaves like an ordinary advance, plus a one-cycle flag.
      stall_cnt_d = '0;
      timeout_d   = forced;
      if (state_q == ST_RUN) begin
        instr_d = imem_data;
        pc1_d   = pc_inc;
        valid_d = 1'b1;
        pc_d    = pc_inc;
        count_d = count_q + 16'd1;
        if (imem_data[15:12] == HALT_OP) begin
          state_d = ST_HALT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      instr_q     <= NOP_INSTR;
      pc1_q       <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc1_q       <= pc1_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
    end
  end

  assign imem_addr     = pc_q;
  assign if_id_instr   = instr_q;
  assign if_id_pc1     = pc1_q;
  assign if_id_valid   = valid_q;
  assign halted        = (state_q == ST_HALT);
  assign stall_timeout = timeout_q;
  assign fetch_count   = count_q;
  assign id_bubble     = ~valid_q | (hazard & ~redirect & under_lim);

endmodule
